// File: rtl/hdmi_cfg_seq.sv
// hdmi_cfg_seq
// Walks a configuration LUT and writes each entry to an HDMI transmitter over
// an external I2C write master. After a start pulse it waits a power-up delay,
// then for each LUT index it fetches {dev_addr, reg_addr, reg_data}, raises a
// write request, and advances on a clean ack. A failed transfer is retried up
// to RETRY_MAX times before the sequence stops in FAIL. An all-ones LUT word
// ends the sequence early.
//
// Ports
//   clk                clock, rising edge
//   rst_n              synchronous active-low reset
//   start              one-cycle pulse, accepted in IDLE/DONE/FAIL
//   lut_index   [9:0]  LUT address
//   lut_data    [31:0] LUT word {dev_addr[31:24], reg_addr[23:8], reg_data[7:0]}
//   i2c_write_req      write request level, held until ack
//   i2c_slave_addr [7:0], i2c_reg_addr [15:0], i2c_reg_data [7:0]
//                      transfer fields, stable while i2c_write_req is high
//   i2c_addr_2byte     register address width select (ADDR_2BYTE)
//   i2c_write_req_ack  one-cycle completion pulse from the master
//   i2c_error          qualifies the ack: 1 = NACK / bus error
//   busy, done, error  status decoded from the state
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start after reset
// S_WAIT  | power-up delay, counts up to DELAY_CYCLES
// S_FETCH | sample lut_data, detect end marker, load transfer fields
// S_REQ   | write request raised, waiting for the master's ack
// S_NEXT  | entry written, step to next index or finish
// S_DONE  | all entries written (sticky until start)
// S_FAIL  | retries exhausted, lut_index holds failing entry (sticky)

module hdmi_cfg_seq #(
  parameter int          LUT_NUM      = 6,
  parameter logic [15:0] DELAY_CYCLES = 16'd1000,
  parameter int          RETRY_MAX    = 3,
  parameter bit          ADDR_2BYTE   = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [9:0]  lut_index,
  input  logic [31:0] lut_data,
  output logic        i2c_write_req,
  output logic [7:0]  i2c_slave_addr,
  output logic [15:0] i2c_reg_addr,
  output logic [7:0]  i2c_reg_data,
  output logic        i2c_addr_2byte,
  input  logic        i2c_write_req_ack,
  input  logic        i2c_error,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_REQ   = 3'd3;
  localparam logic [2:0] S_NEXT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_FAIL  = 3'd6;

  localparam logic [9:0]  LAST_INDEX = 10'(LUT_NUM - 1);
  localparam logic [2:0]  RETRY_LIM  = 3'(RETRY_MAX);
  localparam logic [31:0] END_MARKER = 32'hFFFF_FFFF;

  logic [2:0]  state;
  logic [15:0] delay_cnt;
  logic [2:0]  retry_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      lut_index      <= 10'd0;
      delay_cnt      <= 16'd0;
      retry_cnt      <= 3'd0;
      i2c_write_req  <= 1'b0;
      i2c_slave_addr <= 8'd0;
      i2c_reg_addr   <= 16'd0;
      i2c_reg_data   <= 8'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (start) begin
            state     <= S_WAIT;
            lut_index <= 10'd0;
            delay_cnt <= 16'd0;
            retry_cnt <= 3'd0;
          end
        end

        // Counter stops at DELAY_CYCLES, so WAIT lasts DELAY_CYCLES+1 cycles.
        S_WAIT: begin
          if (delay_cnt == DELAY_CYCLES) begin
            state <= S_FETCH;
          end else begin
            delay_cnt <= delay_cnt + 16'd1;
          end
        end

        // Request is raised here so it is already high in the first REQ cycle.
        S_FETCH: begin
          if (lut_data == END_MARKER) begin
            state <= S_DONE;
          end else begin
            i2c_slave_addr <= lut_data[31:24];
            i2c_reg_addr   <= lut_data[23:8];
            i2c_reg_data   <= lut_data[7:0];
            i2c_write_req  <= 1'b1;
            state          <= S_REQ;
          end
        end

        S_REQ: begin
          if (i2c_write_req_ack) begin
            i2c_write_req <= 1'b0;
            if (!i2c_error) begin
              retry_cnt <= 3'd0;
              state     <= S_NEXT;
            end else if (retry_cnt < RETRY_LIM) begin
              // Re-fetch the same index; this gives the one-cycle request gap.
              retry_cnt <= retry_cnt + 3'd1;
              state     <= S_FETCH;
            end else begin
              state <= S_FAIL;
            end
          end
        end

        S_NEXT: begin
          if (lut_index == LAST_INDEX) begin
            state <= S_DONE;
          end else begin
            lut_index <= lut_index + 10'd1;
            state     <= S_FETCH;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy           = !((state == S_IDLE) || (state == S_DONE) || (state == S_FAIL));
  assign done           = (state == S_DONE);
  assign error          = (state == S_FAIL);
  assign i2c_addr_2byte = ADDR_2BYTE;

endmodule

// File: tb/tb_hdmi_cfg_seq.sv
// Bench for hdmi_cfg_seq. A bench-side I2C master acks every request 10
// cycles after it rises, failing attempts according to err_tab. For each run
// a timeline model (request windows, end cycle, final index) is computed from
// the sequencing rules and compared against the DUT on every cycle.

module tb_hdmi_cfg_seq;

  localparam int DLY  = 4;
  localparam int RMAX = 3;
  localparam int LNUM = 6;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [9:0]  lut_index;
  logic [31:0] lut_data;
  logic        i2c_write_req, i2c_addr_2byte;
  logic [7:0]  i2c_slave_addr, i2c_reg_data;
  logic [15:0] i2c_reg_addr;
  logic        ack_w, err_w, busy, done, error;

  always #5 clk = ~clk;

  logic [31:0] lut_mem [8];
  int          err_tab [8];
  assign lut_data = (lut_index < 10'd8) ? lut_mem[lut_index[2:0]] : 32'h0;

  hdmi_cfg_seq #(
    .LUT_NUM(LNUM), .DELAY_CYCLES(16'(DLY)), .RETRY_MAX(RMAX), .ADDR_2BYTE(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .lut_index(lut_index), .lut_data(lut_data),
    .i2c_write_req(i2c_write_req), .i2c_slave_addr(i2c_slave_addr),
    .i2c_reg_addr(i2c_reg_addr), .i2c_reg_data(i2c_reg_data),
    .i2c_addr_2byte(i2c_addr_2byte),
    .i2c_write_req_ack(ack_w), .i2c_error(err_w),
    .busy(busy), .done(done), .error(error)
  );

  // Bench I2C master plus cycle counter.
  int   cyc = 0;
  int   scn_id = 0;
  logic m_ack = 1'b0, m_err = 1'b0, m_prev = 1'b0;
  logic spur_ack = 1'b0;
  assign ack_w = m_ack | spur_ack;
  assign err_w = m_ack ? m_err : spur_ack;

  initial begin
    int ack_at, cur_e, seen_id;
    int att_n [8];
    ack_at = -1; cur_e = 0; seen_id = 0;
    for (int i = 0; i < 8; i++) att_n[i] = 0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (scn_id != seen_id) begin
        seen_id = scn_id;
        for (int i = 0; i < 8; i++) att_n[i] = 0;
      end
      m_ack = 1'b0;
      m_err = 1'b0;
      if (i2c_write_req && !m_prev) begin
        cur_e = int'(lut_index[2:0]);
        att_n[cur_e]++;
        ack_at = cyc + 10;
      end
      m_prev = i2c_write_req;
      if (cyc == ack_at) begin
        m_ack = 1'b1;
        m_err = (att_n[cur_e] <= err_tab[cur_e]);
      end
    end
  end

  // Timeline model.
  int att_entry [64];
  int att_rise  [64];
  int n_att, end_cyc, end_idx, rst_cyc, win_lo, win_hi, s_cur;
  bit end_err, model_on;

  function automatic void build_model(input int s);
    int t, e, k, a;
    n_att = 0; t = s + DLY + 3; e = 0; k = 0;
    end_err = 1'b0; end_cyc = 1 << 30; end_idx = 0; rst_cyc = 1 << 30;
    for (int it = 0; it < 64; it++) begin
      if (lut_mem[e] == 32'hFFFF_FFFF) begin
        end_cyc = t; end_idx = e; break;
      end
      att_entry[n_att] = e; att_rise[n_att] = t; n_att++;
      a = t + 10;
      if (k < err_tab[e]) begin
        if (k == RMAX) begin
          end_err = 1'b1; end_cyc = a + 1; end_idx = e; break;
        end
        k++; t = a + 2;
      end else if (e == LNUM - 1) begin
        end_cyc = a + 2; end_idx = e; break;
      end else begin
        e++; k = 0; t = a + 3;
      end
    end
  endfunction

  // Checking.
  int total = 0, bad = 0;
  int obs_n;
  int obs_rise [32];
  int obs_idx  [32];
  logic [31:0] obs_word [32];
  logic prev_req = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad < 40) $display("FAIL %s got=%h want=%h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  task automatic cmp_cycle();
    int j, e;
    if (cyc < win_lo || cyc > win_hi) return;
    chk("addr_2byte", 32'(i2c_addr_2byte), 32'd0);
    if (cyc >= rst_cyc) begin
      chk("rst_req",   32'(i2c_write_req), 32'd0);
      chk("rst_busy",  32'(busy), 32'd0);
      chk("rst_done",  32'(done), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      chk("rst_idx",   32'(lut_index), 32'd0);
      chk("rst_word",  {i2c_slave_addr, i2c_reg_addr, i2c_reg_data}, 32'd0);
      return;
    end
    j = -1;
    for (int i = 0; i < n_att; i++)
      if (cyc >= att_rise[i] && cyc <= att_rise[i] + 10) j = i;
    chk("req",   32'(i2c_write_req), 32'(j >= 0));
    chk("busy",  32'(busy),  32'(cyc < end_cyc));
    chk("done",  32'(done),  32'(cyc >= end_cyc && !end_err));
    chk("error", 32'(error), 32'(cyc >= end_cyc && end_err));
    if (j >= 0) begin
      e = att_entry[j];
      chk("req_word", {i2c_slave_addr, i2c_reg_addr, i2c_reg_data}, lut_mem[e]);
      chk("req_idx", 32'(lut_index), 32'(e));
    end
    if (cyc >= end_cyc) chk("end_idx", 32'(lut_index), 32'(end_idx));
    else if (n_att > 0 && cyc < att_rise[0]) chk("wait_idx", 32'(lut_index), 32'd0);
  endtask

  task automatic step();
    @(negedge clk);
    if (model_on) cmp_cycle();
    if (i2c_write_req && !prev_req && obs_n < 32) begin
      obs_rise[obs_n] = cyc;
      obs_idx[obs_n]  = int'(lut_index);
      obs_word[obs_n] = {i2c_slave_addr, i2c_reg_addr, i2c_reg_data};
      obs_n++;
    end
    prev_req = i2c_write_req;
    @(posedge clk);
    #2;
  endtask

  task automatic run_scn(input bit do_rst, input bit noise);
    int k4;
    scn_id++;
    obs_n = 0;
    step();
    if (noise) begin
      spur_ack = 1'b1;
      step();
      spur_ack = 1'b0;
      step();
    end
    s_cur = cyc;
    build_model(s_cur);
    if (do_rst) begin
      k4 = 0;
      for (int i = 0; i < n_att; i++) if (att_entry[i] == 4) begin k4 = i; break; end
      rst_cyc = att_rise[k4] + 4;
      win_hi  = rst_cyc + 20;
    end else begin
      win_hi = end_cyc + 5;
    end
    win_lo = s_cur + 1;
    model_on = 1'b1;
    start = 1'b1;
    while (cyc < win_hi) begin
      step();
      start = 1'b0; spur_ack = 1'b0; rst_n = 1'b1;
      if (noise && cyc == s_cur + 2) begin start = 1'b1; spur_ack = 1'b1; end
      if (noise && cyc == att_rise[2] + 5) start = 1'b1;
      if (do_rst && cyc == rst_cyc - 1) rst_n = 1'b0;
    end
    model_on = 1'b0;
    start = 1'b0; spur_ack = 1'b0; rst_n = 1'b1;
  endtask

  function automatic int count_idx(input int e);
    int c = 0;
    for (int i = 0; i < obs_n; i++) if (obs_idx[i] == e) c++;
    return c;
  endfunction

  initial begin
    lut_mem[0] = 32'h72_0008_35; lut_mem[1] = 32'h72_0009_01;
    lut_mem[2] = 32'h72_0041_10; lut_mem[3] = 32'h7A_0002_33;
    lut_mem[4] = 32'h60_0004_11; lut_mem[5] = 32'h60_0005_04;
    lut_mem[6] = 32'h0;          lut_mem[7] = 32'h0;
    for (int i = 0; i < 8; i++) err_tab[i] = 0;
    model_on = 1'b0; obs_n = 0; n_att = 0; s_cur = 0;
    win_lo = 0; win_hi = 0; rst_cyc = 1 << 30; end_cyc = 0;
    rst_n = 1'b0; start = 1'b0;
    repeat (3) step();
    chk("init_req",   32'(i2c_write_req), 32'd0);
    chk("init_busy",  32'(busy), 32'd0);
    chk("init_done",  32'(done), 32'd0);
    chk("init_error", 32'(error), 32'd0);
    chk("init_idx",   32'(lut_index), 32'd0);
    chk("init_word",  {i2c_slave_addr, i2c_reg_addr, i2c_reg_data}, 32'd0);
    rst_n = 1'b1;
    step();

    // A: clean run
    run_scn(1'b0, 1'b0);
    chk("a_model_n",   32'(n_att), 32'd6);
    chk("a_nreq",      32'(obs_n), 32'd6);
    chk("a_first_lat", 32'(obs_rise[0] - s_cur), 32'd7);
    chk("a_gap",       32'(obs_rise[1] - obs_rise[0]), 32'd13);
    chk("a_first",     obs_word[0], 32'h72_0008_35);
    chk("a_last",      obs_word[5], 32'h60_0005_04);
    chk("a_last_idx",  32'(obs_idx[5]), 32'd5);
    chk("a_done",      32'(done), 32'd1);
    chk("a_busy",      32'(busy), 32'd0);

    // B: entry 2 fails twice then succeeds
    err_tab[2] = 2;
    run_scn(1'b0, 1'b0);
    chk("b_nreq",  32'(obs_n), 32'd8);
    chk("b_e2",    32'(count_idx(2)), 32'd3);
    chk("b_rgap",  32'(obs_rise[3] - obs_rise[2]), 32'd12);
    chk("b_done",  32'(done), 32'd1);
    err_tab[2] = 0;

    // C: entry 1 always fails
    err_tab[1] = 7;
    run_scn(1'b0, 1'b0);
    chk("c_nreq",  32'(obs_n), 32'd5);
    chk("c_e1",    32'(count_idx(1)), 32'd4);
    chk("c_e2",    32'(count_idx(2)), 32'd0);
    chk("c_error", 32'(error), 32'd1);
    chk("c_idx",   32'(lut_index), 32'd1);
    err_tab[1] = 0;

    // D: end marker at index 3, restarted from FAIL
    lut_mem[3] = 32'hFFFF_FFFF;
    run_scn(1'b0, 1'b0);
    chk("d_nreq",  32'(obs_n), 32'd3);
    chk("d_done",  32'(done), 32'd1);
    chk("d_error", 32'(error), 32'd0);
    chk("d_idx",   32'(lut_index), 32'd3);
    lut_mem[3] = 32'h7A_0002_33;

    // E: reset while entry 4 is requesting
    run_scn(1'b1, 1'b0);
    chk("e_req",  32'(i2c_write_req), 32'd0);
    chk("e_busy", 32'(busy), 32'd0);
    chk("e_done", 32'(done), 32'd0);
    chk("e_idx",  32'(lut_index), 32'd0);

    // F: fresh start after reset, spurious acks and extra start pulses
    run_scn(1'b0, 1'b1);
    chk("f_nreq",  32'(obs_n), 32'd6);
    chk("f_first", obs_word[0], 32'h72_0008_35);
    chk("f_done",  32'(done), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hdmi_cfg_seq.md
HDMI_CFG_SEQ -- requirements
Module: hdmi_cfg_seq

Interface
REQ-001 Parameter LUT_NUM, default 6: number of LUT entries to write (1..1023).
REQ-002 Parameter DELAY_CYCLES, default 16'd1000: power-up wait in clk cycles after start, before the first transfer (0 = no wait).
REQ-003 Parameter RETRY_MAX, default 3: retries allowed per entry after a failed transfer (0..7).
REQ-004 Parameter ADDR_2BYTE, default 0: drives i2c_addr_2byte (1 = 16-bit register address, 0 = 8-bit).
REQ-005 clk  input  1  system clock; all logic rising-edge.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 start  input  1  one-cycle pulse; begins the configuration sequence when idle.
REQ-008 lut_index  output  10  address presented to the config LUT.
REQ-009 lut_data  input  32  combinational LUT output {dev_addr[31:24], reg_addr[23:8], reg_data[7:0]}.
REQ-010 i2c_write_req  output  1  write request to the I2C master; level, held until ack.
REQ-011 i2c_slave_addr  output  8  8-bit device address for the current transfer.
REQ-012 i2c_reg_addr  output  16  register address for the current transfer.
REQ-013 i2c_reg_data  output  8  register data for the current transfer.
REQ-014 i2c_addr_2byte  output  1  register-address width select; constant ADDR_2BYTE.
REQ-015 i2c_write_req_ack  input  1  one-cycle pulse from the I2C master: transfer finished.
REQ-016 i2c_error  input  1  valid in the ack cycle; 1 = NACK or bus error.
REQ-017 busy  output  1  high in every state except IDLE, DONE and FAIL.
REQ-018 done  output  1  high in DONE.
REQ-019 error  output  1  high in FAIL.

Function
REQ-020 States: IDLE, WAIT, FETCH, REQ, NEXT, DONE, FAIL.
REQ-021 IDLE: on start=1 -> WAIT; lut_index cleared to 0; delay counter cleared; retry counter cleared.
REQ-022 WAIT: the delay counter increments each cycle; on count == DELAY_CYCLES -> FETCH; with DELAY_CYCLES=0, WAIT lasts one cycle.
REQ-023 FETCH: lut_data is sampled in this single cycle; if lut_data == 32'hFFFF_FFFF (end marker) -> DONE; otherwise the fields are registered into i2c_slave_addr, i2c_reg_addr and i2c_reg_data -> REQ.
REQ-024 REQ: i2c_write_req = 1 from the first REQ cycle; the address and data outputs are stable while i2c_write_req is high.
REQ-025 REQ, on ack with i2c_error=0: i2c_write_req drops on the next cycle; retry counter cleared -> NEXT.
REQ-026 REQ, on ack with i2c_error=1 and retries < RETRY_MAX: retry counter +1; i2c_write_req drops for exactly one cycle (via FETCH of the same index), then the same entry is reissued.
REQ-027 REQ, on ack with i2c_error=1 and retries == RETRY_MAX: -> FAIL; lut_index holds the failing entry.
REQ-028 NEXT: if lut_index == LUT_NUM-1 -> DONE; otherwise lut_index +1 -> FETCH.
REQ-029 Latency: first i2c_write_req rises DELAY_CYCLES+3 cycles after the start pulse; each subsequent request rises 3 cycles after the previous ack (REQ->NEXT->FETCH->REQ).
REQ-030 DONE and FAIL are sticky; start=1 in either state re-runs from WAIT with lut_index=0; done and error clear in that same transition.
REQ-031 start while busy is ignored.
REQ-032 i2c_write_req_ack outside REQ is ignored.
REQ-033 The retry counter is 3 bits and never wraps; the delay counter is 16 bits and saturates at DELAY_CYCLES.
REQ-034 lut_index never exceeds LUT_NUM-1.

Reset
REQ-035 While rst_n=0 at a clk edge: state=IDLE; lut_index=0; i2c_write_req=0; i2c_slave_addr=0; i2c_reg_addr=0; i2c_reg_data=0; busy=0; done=0; error=0; all counters 0.
REQ-036 Reset asserted during REQ drops i2c_write_req on that edge; after release the block waits in IDLE for a new start.

Verification
REQ-037 LUT_NUM=6, DELAY_CYCLES=4, master acks every request after 10 cycles with no error -> 6 requests in index order 0..5; first is {72,0008,35}, last is {60,0005,04}; done=1; busy=0.
REQ-038 Entry 2 returns i2c_error=1 twice, then succeeds; RETRY_MAX=3 -> entry 2 issued 3 times, each reissue preceded by a 1-cycle request gap; done=1.
REQ-039 Entry 1 always returns an error; RETRY_MAX=3 -> 4 attempts; error=1; lut_index=1; no request is ever issued for entry 2.
REQ-040 LUT returns 32'hFFFF_FFFF at index 3, LUT_NUM=6 -> only entries 0..2 are written; done=1.
REQ-041 rst_n=0 pulsed while entry 4 is in REQ -> outputs reach reset values on the next edge; a later start re-runs from index 0.
REQ-042 start pulsed mid-sequence, and a spurious ack in IDLE -> sequence unaffected; no extra requests issued.
